pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Stall and flush controller for the 5-stage MIPS pipeline. It pairs with the ID-stage forwarding mux-select unit and covers every hazard that forwarding cannot resolve: load-use, instruction-cache miss, data-cache miss, and redirect during an outstanding fetch. It drives the enable and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It tracks outstanding cache misses with a small FSM and includes a miss watchdog.

Parameters:
WD_LIMIT, 255, cycles a single miss may stay outstanding before err_timeout is set
WD_W, 8, watchdog counter width; must satisfy WD_LIMIT < 2^WD_W

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous reset, active-high
IF_ID_rs  in  5  rs field of the instruction in ID
IF_ID_rt  in  5  rt field of the instruction in ID
ID_EX_memread  in  1  instruction in EX is a load
ID_EX_regwrite  in  1  instruction in EX writes the register file
ID_EX_WA  in  5  destination register of the instruction in EX
branch_taken  in  1  ID-stage redirect (branch or jump resolved taken)
icache_req  in  1  IF is fetching this cycle
icache_ready  in  1  icache returns data this cycle (hit, or miss fill done)
dcache_req  in  1  MEM-stage load or store active
dcache_ready  in  1  dcache completes the access this cycle
PC_stall  out  1  hold PC
IF_ID_stall  out  1  hold IF/ID
IF_ID_flush  out  1  load NOP into IF/ID
ID_EX_stall  out  1  hold ID/EX
ID_EX_flush  out  1  load NOP into ID/EX
EX_MEM_stall  out  1  hold EX/MEM
MEM_WB_flush  out  1  load NOP into MEM/WB
err_timeout  out  1  sticky watchdog error flag

Behaviour:
- Reset: asynchronous, active-high. The FSM goes to RUN, redir_pend=0, wd_cnt=0, err_timeout=0. All other outputs are forced to 0 while rst=1.
- Miss detection:
  - ic_miss = icache_req & ~icache_ready
  - dc_miss = dcache_req & ~dcache_ready
  - A request with ready in the same cycle is a hit: zero stall.
- FSM states: RUN, IC_WAIT, DC_WAIT, BOTH_WAIT. Transitions are evaluated each clk; ready-in-cycle clears the corresponding pending miss.
  - RUN → IC_WAIT on ic_miss only; → DC_WAIT on dc_miss only; → BOTH_WAIT on both.
  - IC_WAIT → RUN on icache_ready. IC_WAIT → BOTH_WAIT on a new dc_miss without icache_ready.
  - DC_WAIT → RUN on dcache_ready. Icache is not sampled in DC_WAIT because the front end is frozen.
  - BOTH_WAIT → IC_WAIT on dcache_ready only; → DC_WAIT on icache_ready only; → RUN on both.
- Outputs (combinational from state and inputs). Apply priority top to bottom; the first active row wins per stage register:
  1. dc_miss or state ∈ {DC_WAIT, BOTH_WAIT} and not dcache_ready: PC_stall=IF_ID_stall=ID_EX_stall=EX_MEM_stall=1, MEM_WB_flush=1. Whole pipe frozen; WB receives a bubble.
  2. Load-use hazard. Condition: ID_EX_memread & ID_EX_regwrite & ID_EX_WA≠0 & (ID_EX_WA==IF_ID_rs | ID_EX_WA==IF_ID_rt). Action: PC_stall=IF_ID_stall=1, ID_EX_flush=1, for exactly one bubble. After the bubble the load sits in EX/MEM and is forwarded with select code 11.
  3. ic_miss or state ∈ {IC_WAIT, BOTH_WAIT} without icache_ready: PC_stall=1, IF_ID_flush=1. Back end keeps draining.
  4. branch_taken with no stall active: IF_ID_flush=1, which squashes the wrong-path fetch.
- Redirect during fetch miss:
  - branch_taken while in IC_WAIT or BOTH_WAIT sets redir_pend=1.
  - On the icache_ready cycle with redir_pend=1: IF_ID_flush=1 (the stale fetch is discarded) and redir_pend clears.
  - branch_taken in the same cycle as icache_ready behaves as in row 4 and does not set redir_pend.
- Watchdog:
  - wd_cnt increments each cycle state≠RUN and clears on every transition to RUN or on any ready completing a miss.
  - When wd_cnt==WD_LIMIT, err_timeout←1. It stays set until rst and does not affect stalls.
  - wd_cnt saturates at WD_LIMIT.
- Register 0 is never a hazard source.
- rst asserted mid-miss abandons the miss immediately; no outputs remain asserted.

Optional Feature:
Macro STALL_PERF_CNT_EN.
- Defined: adds outputs perf_load_use[31:0], perf_icache_stall[31:0] and perf_dcache_stall[31:0].
  - Each counts the cycles in which the corresponding row 2, 3 or 1 output set is the winning source.
  - Counters wrap modulo 2^32 and reset to 0 on rst.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Load-use: lw writes $5 (ID_EX_memread=1, ID_EX_WA=5) while add in ID reads rs=5 → one cycle of PC_stall=IF_ID_stall=ID_EX_flush=1, then all 0. Repeating with WA=0 → no stall.
- Icache miss for 3 cycles, then icache_ready: states RUN→IC_WAIT (3 cycles)→RUN. PC_stall=IF_ID_flush=1 for the 3 miss cycles; ID_EX_stall stays 0 throughout.
- Dcache miss overlapping an icache miss: dc_miss in IC_WAIT → BOTH_WAIT, with all stalls and MEM_WB_flush=1. dcache_ready → IC_WAIT; icache_ready → RUN.
- branch_taken in cycle 2 of a 4-cycle icache miss → IF_ID_flush=1 on the icache_ready cycle, then redir_pend=0.
- Dcache miss held for WD_LIMIT=255 cycles → err_timeout=1 at cycle 255. It remains 1 after dcache_ready and clears only on rst.
- rst pulse in DC_WAIT → all outputs 0 at once. After release, state=RUN and wd_cnt=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//
// Stall and flush controller for the 5-stage MIPS pipeline. It covers the hazards that
// forwarding cannot resolve: load-use, icache miss, dcache miss, and a redirect that
// arrives while a fetch miss is outstanding. A small FSM tracks the outstanding misses,
// and a watchdog flags any miss that stays outstanding too long.
//
// Optional feature: define STALL_PERF_CNT_EN to add the stall-cycle performance counters.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   IF_ID_rs, IF_ID_rt           source registers of the instruction in ID
//   ID_EX_memread/regwrite/WA    load flag, write flag and destination of the instr in EX
//   branch_taken                 ID-stage redirect
//   icache_req/ready             fetch request and its completion
//   dcache_req/ready             MEM-stage access and its completion
//   PC_stall .. MEM_WB_flush     pipeline register hold/bubble controls
//   err_timeout                  sticky watchdog error
//   perf_* (optional)            cycles won by the load-use / icache / dcache rows
module pipeline_hazard_ctrl #(
  parameter int unsigned WD_LIMIT = 255,
  parameter int unsigned WD_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IF_ID_rs,
  input  logic [4:0]  IF_ID_rt,
  input  logic        ID_EX_memread,
  input  logic        ID_EX_regwrite,
  input  logic [4:0]  ID_EX_WA,
  input  logic        branch_taken,
  input  logic        icache_req,
  input  logic        icache_ready,
  input  logic        dcache_req,
  input  logic        dcache_ready,
  output logic        PC_stall,
  output logic        IF_ID_stall,
  output logic        IF_ID_flush,
  output logic        ID_EX_stall,
  output logic        ID_EX_flush,
  output logic        EX_MEM_stall,
  output logic        MEM_WB_flush,
  output logic        err_timeout
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] perf_load_use,
  output logic [31:0] perf_icache_stall,
  output logic [31:0] perf_dcache_stall
`endif
);

  typedef enum logic [1:0] {StRun, StIcWait, StDcWait, StBothWait} state_e;

  state_e            state_q, state_d;
  logic              redir_pend_q, redir_pend_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              err_q, err_d;

  logic ic_miss, dc_miss, ic_pend, dc_pend;
  logic dc_stall, ic_stall, load_use, redir_done, miss_done;

  assign ic_miss = icache_req & ~icache_ready;
  assign dc_miss = dcache_req & ~dcache_ready;
  assign ic_pend = (state_q == StIcWait) || (state_q == StBothWait);
  assign dc_pend = (state_q == StDcWait) || (state_q == StBothWait);

  assign dc_stall   = (dc_miss | dc_pend) & ~dcache_ready;
  assign ic_stall   = (ic_miss | ic_pend) & ~icache_ready;
  assign load_use   = ID_EX_memread & ID_EX_regwrite & (ID_EX_WA != 5'd0) &
                      ((ID_EX_WA == IF_ID_rs) | (ID_EX_WA == IF_ID_rt));
  assign redir_done = redir_pend_q & icache_ready;
  assign miss_done  = (ic_pend & icache_ready) | (dc_pend & dcache_ready);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (ic_miss && dc_miss) state_d = StBothWait;
        else if (ic_miss)       state_d = StIcWait;
        else if (dc_miss)       state_d = StDcWait;
      end
      StIcWait: begin
        // A dcache miss starting on the fill cycle is still outstanding afterwards.
        if (icache_ready) state_d = dc_miss ? StDcWait : StRun;
        else if (dc_miss) state_d = StBothWait;
      end
      // Front end is frozen here, so the icache is not sampled.
      StDcWait: begin
        if (dcache_ready) state_d = StRun;
      end
      StBothWait: begin
        if (icache_ready && dcache_ready) state_d = StRun;
        else if (dcache_ready)            state_d = StIcWait;
        else if (icache_ready)            state_d = StDcWait;
      end
      default: state_d = StRun;
    endcase
  end

  // Output logic: rows in priority order, first active row owns the controls.
  always_comb begin
    PC_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_stall  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_stall = 1'b0;
    MEM_WB_flush = 1'b0;
    if (!rst) begin
      if (dc_stall) begin
        PC_stall     = 1'b1;
        IF_ID_stall  = 1'b1;
        ID_EX_stall  = 1'b1;
        EX_MEM_stall = 1'b1;
        MEM_WB_flush = 1'b1;
      end else if (load_use) begin
        PC_stall    = 1'b1;
        IF_ID_stall = 1'b1;
        ID_EX_flush = 1'b1;
      end else if (ic_stall) begin
        PC_stall    = 1'b1;
        IF_ID_flush = 1'b1;
      end else if (branch_taken) begin
        IF_ID_flush = 1'b1;
      end
      // The fill that completes after a redirect is wrong-path: drop it even if the
      // pipe is otherwise holding (IF/ID only carries bubbles during a fetch miss).
      if (redir_done) begin
        IF_ID_flush = 1'b1;
        IF_ID_stall = 1'b0;
      end
    end
  end

  // Redirect-pending and watchdog next state
  always_comb begin
    redir_pend_d = (redir_pend_q | (branch_taken & ic_pend)) & ~icache_ready;

    if (state_q == StRun || state_d == StRun || miss_done) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != WD_W'(WD_LIMIT)) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end else begin
      wd_cnt_d = wd_cnt_q;
    end

    err_d = err_q | ((state_q != StRun) && (wd_cnt_q == WD_W'(WD_LIMIT)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redir_pend_q <= 1'b0;
      wd_cnt_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      redir_pend_q <= redir_pend_d;
      wd_cnt_q     <= wd_cnt_d;
      err_q        <= err_d;
    end
  end

  assign err_timeout = err_q;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_lu_q, perf_ic_q, perf_dc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lu_q <= '0;
      perf_ic_q <= '0;
      perf_dc_q <= '0;
    end else begin
      if (dc_stall)                           perf_dc_q <= perf_dc_q + 32'd1;
      if (!dc_stall && load_use)              perf_lu_q <= perf_lu_q + 32'd1;
      if (!dc_stall && !load_use && ic_stall) perf_ic_q <= perf_ic_q + 32'd1;
    end
  end

  assign perf_load_use     = perf_lu_q;
  assign perf_icache_stall = perf_ic_q;
  assign perf_dcache_stall = perf_dc_q;
`endif

endmodule
